// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: 16-bit little-endian word count, then
// little-endian 32-bit words. Optional checksum check under IMEM_LOADER_CKSUM_EN.
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clka,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
`ifdef IMEM_LOADER_CKSUM_EN
  localparam logic [2:0] S_CHK  = 3'd3;
`endif
  localparam logic [2:0] S_DONE = 3'd4;

`ifdef IMEM_LOADER_CKSUM_EN
  localparam logic [2:0] S_AFTER_DATA = S_CHK;
`else
  localparam logic [2:0] S_AFTER_DATA = S_DONE;
`endif

  // Largest word count that still fits in the memory without wrapping waddr.
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  logic [2:0]        state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [15:0]       word_cnt_q, word_cnt_d;
  logic [15:0]       len_q, len_d;
  logic [23:0]       asm_q, asm_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic        xfer;
  logic [15:0] len_full;

`ifdef IMEM_LOADER_CKSUM_EN
  assign s_ready = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHK);
`else
  assign s_ready = (state_q == S_LEN) || (state_q == S_DATA);
`endif
  assign xfer     = s_valid && s_ready;
  assign len_full = {s_data, len_q[7:0]};

  assign busy  = (state_q != S_IDLE);
  assign done  = (state_q == S_DONE);
  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign err   = err_q;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    len_d      = len_q;
    asm_d      = asm_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
`ifdef IMEM_LOADER_CKSUM_EN
    csum_d     = csum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LEN;
          byte_cnt_d = 2'd0;
          word_cnt_d = 16'd0;
          len_d      = 16'd0;
          waddr_d    = '0;
          err_d      = 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
          csum_d     = 8'd0;
`endif
        end
      end

      S_LEN: begin
        if (xfer) begin
          if (byte_cnt_q == 2'd0) begin
            len_d[7:0] = s_data;
            byte_cnt_d = 2'd1;
          end else begin
            len_d      = len_full;
            byte_cnt_d = 2'd0;
            if (len_full == 16'd0) begin
              state_d = S_DONE;
            end else if ({1'b0, len_full} > MAX_WORDS) begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end

      S_DATA: begin
        if (xfer) begin
`ifdef IMEM_LOADER_CKSUM_EN
          csum_d = csum_q ^ s_data;
`endif
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: asm_d[7:0]   = s_data;
            2'd1: asm_d[15:8]  = s_data;
            2'd2: asm_d[23:16] = s_data;
            default: begin
              // Fourth byte completes the word; the write strobe lands next cycle.
              we_d       = 1'b1;
              waddr_d    = word_cnt_q[ADDR_W-1:0];
              wdata_d    = {s_data, asm_q};
              word_cnt_d = word_cnt_q + 16'd1;
              if (word_cnt_q + 16'd1 == len_q) begin
                state_d = S_AFTER_DATA;
              end
            end
          endcase
        end
      end

`ifdef IMEM_LOADER_CKSUM_EN
      S_CHK: begin
        if (xfer) begin
          if (s_data != csum_q) begin
            err_d = 1'b1;
          end
          state_d = S_DONE;
        end
      end
`endif

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clka) begin
    if (rst) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= 2'd0;
      word_cnt_q <= 16'd0;
      len_q      <= 16'd0;
      asm_q      <= 24'd0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= 32'd0;
      err_q      <= 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
      csum_q     <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      len_q      <= len_d;
      asm_q      <= asm_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
`ifdef IMEM_LOADER_CKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes and done/err pairs are queued
// by the stimulus and popped by an independent monitor on the falling edge.
module tb_imem_loader;

  localparam int ADDR_W = 10;

  logic              clka = 1'b0;
  logic              rst;
  logic              start;
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;
  logic              busy;
  logic              done;
  logic              err;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t  exp_wr_q[$];
  logic exp_done_q[$];
  logic done_prev = 1'b0;

  int compared   = 0;
  int mismatched = 0;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clka    (clka),
    .rst     (rst),
    .start   (start),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clka = ~clka;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic failNote(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: event not expected or not reached at %0t", name, $time);
  endtask

  // Monitor: pops the scoreboard whenever the DUT writes or pulses done.
  always @(negedge clka) begin : monitor
    wr_t  e;
    logic exp_err;
    if (!rst && we) begin
      if (exp_wr_q.size() == 0) begin
        failNote("unexpected_we");
      end else begin
        e = exp_wr_q.pop_front();
        checkOutput("waddr", 32'(waddr), 32'(e.addr));
        checkOutput("wdata", wdata, e.data);
      end
    end
    if (!rst && done) begin
      checkOutput("done_single_cycle", 32'(done_prev), 32'd0);
      if (exp_done_q.size() == 0) begin
        failNote("unexpected_done");
      end else begin
        exp_err = exp_done_q.pop_front();
        checkOutput("err_at_done", 32'(err), 32'(exp_err));
      end
    end
    done_prev <= done && !rst;
  end

  function automatic logic [7:0] cksumOf(input logic [7:0] bq[$]);
    logic [7:0] x = 8'd0;
    for (int i = 2; i < bq.size(); i++) x ^= bq[i];
    return x;
  endfunction

  // Present one byte after 'gap' idle cycles and hold it until accepted.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    bit ok = 1'b0;
    s_valid = 1'b0;
    repeat (gap) begin
      @(posedge clka);
      #1;
    end
    s_valid = 1'b1;
    s_data  = b;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clka);
      ok = s_ready;
      @(posedge clka);
      #1;
    end
    s_valid = 1'b0;
    if (!ok) failNote("byte_accept_timeout");
  endtask

  task automatic sendStream(input logic [7:0] bq[$], input bit stall);
    for (int i = 0; i < bq.size(); i++) applyStimulus(bq[i], stall ? (i % 5) + 1 : 0);
  endtask

  task automatic startLoad();
    start = 1'b1;
    @(posedge clka);
    #1;
    start = 1'b0;
  endtask

  task automatic waitIdle();
    bit idle = 1'b0;
    for (int i = 0; i < 100 && !idle; i++) begin
      @(negedge clka);
      idle = !busy;
    end
    @(posedge clka);
    #1;
    if (!idle) failNote("wait_idle_timeout");
  endtask

  task automatic twoWordLoad(input bit stall);
    logic [7:0] bq[$];
    bq = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef IMEM_LOADER_CKSUM_EN
    bq.push_back(cksumOf(bq));
`endif
    exp_wr_q.push_back('{addr: 10'd0, data: 32'h12345678});
    exp_wr_q.push_back('{addr: 10'd1, data: 32'hDEADBEEF});
    exp_done_q.push_back(1'b0);
    startLoad();
    sendStream(bq, stall);
    waitIdle();
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [7:0] bq[$];
    logic [31:0] w;

    rst = 1'b1;
    start = 1'b0;
    s_valid = 1'b0;
    s_data = 8'h00;
    repeat (3) @(posedge clka);
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_s_ready", 32'(s_ready), 32'd0);
    checkOutput("rst_we", 32'(we), 32'd0);
    checkOutput("rst_waddr", 32'(waddr), 32'd0);
    checkOutput("rst_wdata", wdata, 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    @(posedge clka);
    #1;

    $display("[TB] two-word load");
    twoWordLoad(1'b0);

    $display("[TB] zero-length load");
    exp_done_q.push_back(1'b0);
    startLoad();
    checkOutput("len_busy", 32'(busy), 32'd1);
    checkOutput("len_s_ready", 32'(s_ready), 32'd1);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h00, 0);
    checkOutput("zero_done_next", 32'(done), 32'd1);
    checkOutput("zero_done_s_ready", 32'(s_ready), 32'd0);
    @(posedge clka);
    #1;
    checkOutput("zero_busy_after", 32'(busy), 32'd0);
    checkOutput("zero_done_after", 32'(done), 32'd0);

    $display("[TB] stalled two-word load");
    twoWordLoad(1'b1);

    $display("[TB] reset mid-load");
    startLoad();
    bq = '{8'h01, 8'h00, 8'h78, 8'h56};
    sendStream(bq, 1'b0);
    rst = 1'b1;
    @(posedge clka);
    #1;
    rst = 1'b0;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_we", 32'(we), 32'd0);
    checkOutput("midrst_waddr", 32'(waddr), 32'd0);
    repeat (3) @(posedge clka);
    #1;
    bq = '{8'h01, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
`ifdef IMEM_LOADER_CKSUM_EN
    bq.push_back(cksumOf(bq));
`endif
    exp_wr_q.push_back('{addr: 10'd0, data: 32'hCAFEF00D});
    exp_done_q.push_back(1'b0);
    startLoad();
    sendStream(bq, 1'b0);
    waitIdle();

    $display("[TB] overflow length");
    exp_done_q.push_back(1'b1);
    startLoad();
    bq = '{8'h01, 8'h04};
    sendStream(bq, 1'b0);
    waitIdle();
    checkOutput("ovf_err_sticky", 32'(err), 32'd1);
    repeat (4) @(posedge clka);
    #1;
    checkOutput("ovf_err_still", 32'(err), 32'd1);
    exp_done_q.push_back(1'b0);
    startLoad();
    checkOutput("ovf_err_cleared", 32'(err), 32'd0);
    bq = '{8'h00, 8'h00};
    sendStream(bq, 1'b0);
    waitIdle();

    $display("[TB] full-capacity load");
    bq = '{8'h00, 8'h04};
    for (int i = 0; i < 1024; i++) begin
      w = 32'h5A000000 ^ (32'(i) * 32'h00010203);
      bq.push_back(w[7:0]);
      bq.push_back(w[15:8]);
      bq.push_back(w[23:16]);
      bq.push_back(w[31:24]);
      exp_wr_q.push_back('{addr: 10'(i), data: w});
    end
`ifdef IMEM_LOADER_CKSUM_EN
    bq.push_back(cksumOf(bq));
`endif
    exp_done_q.push_back(1'b0);
    startLoad();
    sendStream(bq, 1'b0);
    waitIdle();

`ifdef IMEM_LOADER_CKSUM_EN
    $display("[TB] checksum good and bad");
    exp_wr_q.push_back('{addr: 10'd0, data: 32'h12345678});
    exp_done_q.push_back(1'b0);
    startLoad();
    bq = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    sendStream(bq, 1'b0);
    waitIdle();
    checkOutput("cksum_good_err", 32'(err), 32'd0);
    exp_wr_q.push_back('{addr: 10'd0, data: 32'h12345678});
    exp_done_q.push_back(1'b1);
    startLoad();
    bq = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09};
    sendStream(bq, 1'b0);
    waitIdle();
    checkOutput("cksum_bad_err", 32'(err), 32'd1);
`endif

    repeat (5) @(posedge clka);
    #1;
    checkOutput("pending_writes", 32'(exp_wr_q.size()), 32'd0);
    checkOutput("pending_dones", 32'(exp_done_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
